// File: rtl/mmio_serial_tx.sv
// Memory-mapped serial transmitter: CPU pushes words into a TX FIFO and polls
// STATUS; words are sent as start / data (LSB first) / stop frames on the line output.
// Optional even-parity bit between data and stop: define MMIO_SERIAL_TX_PARITY_EN.
module mmio_serial_tx #(
   parameter int unsigned       ADDR_W     = 8,
   parameter int unsigned       DATA_W     = 16,
   parameter int unsigned       FIFO_DEPTH = 4,
   parameter int unsigned       CLK_DIV    = 1,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(8'hFE)
) (
   input  logic              ck,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] dataW,
   input  logic              ce,
   input  logic              we,
   output logic              hit,
   output logic [DATA_W-1:0] rdata,
   output logic              line,
   output logic              busy
);

   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [ADDR_W-1:0] DATA_ADDR = BASE_ADDR + ADDR_W'(1);
   localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

`ifdef MMIO_SERIAL_TX_PARITY_EN
   localparam logic PAR_FLAG = 1'b1;
`else
   localparam logic PAR_FLAG = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t              state, state_n;
   logic [BAUD_W-1:0]   baud, baud_n;
   logic [IDX_W-1:0]    idx, idx_n;
   logic [DATA_W-1:0]   shreg, shreg_n;
   logic                line_n;
   logic                busy_n;
`ifdef MMIO_SERIAL_TX_PARITY_EN
   logic                par_q, par_n;
`endif

   logic [DATA_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    count;
   logic                overflow;

   logic                sel_status, sel_data;
   logic                push_req, push_ok, pop;
   logic                empty, full, bit_done;
   logic [4:0]          status_bits;

   // Bus decode and STATUS read mux
   assign sel_status  = ce && (address == BASE_ADDR);
   assign sel_data    = ce && (address == DATA_ADDR);
   assign hit         = sel_status || sel_data;
   assign status_bits = {PAR_FLAG, overflow, full, empty, busy};
   assign rdata       = sel_status ? DATA_W'(status_bits) : '0;

   // FIFO flags; a push into a full FIFO is still accepted when a pop frees a slot
   assign empty    = (count == '0);
   assign full     = (count == CNT_FULL);
   assign push_req = sel_data && we;
   assign push_ok  = push_req && (!full || pop);
   assign bit_done = (baud == BAUD_LAST);

   // Next-state logic for the frame sequencer; line/busy follow the next state
   always_comb begin
      state_n = state;
      baud_n  = baud;
      idx_n   = idx;
      shreg_n = shreg;
      pop     = 1'b0;
      line_n  = 1'b1;
      busy_n  = 1'b0;
`ifdef MMIO_SERIAL_TX_PARITY_EN
      par_n   = par_q;
`endif
      case (state)
         IDLE: begin
            baud_n = '0;
            if (!empty) begin
               pop     = 1'b1;
               shreg_n = mem[rd_ptr];
               state_n = START;
`ifdef MMIO_SERIAL_TX_PARITY_EN
               par_n   = ^mem[rd_ptr];
`endif
            end
         end
         START: begin
            if (bit_done) begin
               baud_n  = '0;
               idx_n   = '0;
               state_n = DATA;
            end else begin
               baud_n = baud + BAUD_W'(1);
            end
         end
         DATA: begin
            if (bit_done) begin
               baud_n  = '0;
               shreg_n = shreg >> 1;
               if (idx == IDX_LAST) begin
`ifdef MMIO_SERIAL_TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end else begin
               baud_n = baud + BAUD_W'(1);
            end
         end
`ifdef MMIO_SERIAL_TX_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               baud_n  = '0;
               state_n = STOP;
            end else begin
               baud_n = baud + BAUD_W'(1);
            end
         end
`endif
         STOP: begin
            if (bit_done) begin
               baud_n = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shreg_n = mem[rd_ptr];
                  state_n = START;
`ifdef MMIO_SERIAL_TX_PARITY_EN
                  par_n   = ^mem[rd_ptr];
`endif
               end else begin
                  state_n = IDLE;
               end
            end else begin
               baud_n = baud + BAUD_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            baud_n  = '0;
         end
      endcase

      case (state_n)
         START:   line_n = 1'b0;
         DATA:    line_n = shreg_n[0];
`ifdef MMIO_SERIAL_TX_PARITY_EN
         PARITY:  line_n = par_n;
`endif
         default: line_n = 1'b1;
      endcase
      busy_n = (state_n != IDLE);
   end

   // Sequencer state and registered serial outputs
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         baud  <= '0;
         idx   <= '0;
         shreg <= '0;
         line  <= 1'b1;
         busy  <= 1'b0;
`ifdef MMIO_SERIAL_TX_PARITY_EN
         par_q <= 1'b0;
`endif
      end else begin
         state <= state_n;
         baud  <= baud_n;
         idx   <= idx_n;
         shreg <= shreg_n;
         line  <= line_n;
         busy  <= busy_n;
`ifdef MMIO_SERIAL_TX_PARITY_EN
         par_q <= par_n;
`endif
      end
   end

   // FIFO storage, written on accepted pushes only
   always_ff @(posedge ck) begin
      if (push_ok) begin
         mem[wr_ptr] <= dataW;
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
         end
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (push_req && !push_ok) begin
            overflow <= 1'b1;
         end else if (sel_status && we && dataW[3]) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule
